// File: rtl/gfx256_rdarb_if.sv
// Bus bundle for the three-way read arbiter.
// slave  : arbiter view (requester inputs and reader responses in, acks and reader request out).
// master : environment view (requesters plus wishbone reader model).
interface gfx256_rdarb_if;
  logic        req0_i, req1_i, req2_i;
  logic [31:0] addr0_i, addr1_i, addr2_i;
  logic [31:0] sel0_i, sel1_i, sel2_i;
  logic        ack0_o, ack1_o, ack2_o;
  logic [31:0] data_o;
  logic        wbm_request_o;
  logic [31:0] wbm_addr_o;
  logic [31:0] wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_data_i;
  logic        wbm_busy_i;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic        timeout_o;

  modport slave (
    input  req0_i, req1_i, req2_i, addr0_i, addr1_i, addr2_i, sel0_i, sel1_i, sel2_i,
    input  wbm_ack_i, wbm_data_i, wbm_busy_i,
    output ack0_o, ack1_o, ack2_o, data_o, wbm_request_o, wbm_addr_o, wbm_sel_o,
    output grant_o, busy_o, timeout_o
  );

  modport master (
    output req0_i, req1_i, req2_i, addr0_i, addr1_i, addr2_i, sel0_i, sel1_i, sel2_i,
    output wbm_ack_i, wbm_data_i, wbm_busy_i,
    input  ack0_o, ack1_o, ack2_o, data_o, wbm_request_o, wbm_addr_o, wbm_sel_o,
    input  grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/gfx256_rdarb.sv
// gfx256_rdarb: round-robin arbiter sharing one wishbone read master
// between blender target reads (0), texture fetches (1) and depth fetches (2).
// Optional macro GFX256_RDARB_TIMEOUT_EN adds a BUSY watchdog that forces
// completion with all-ones data after TIMEOUT_CYCLES cycles.
module gfx256_rdarb #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  gfx256_rdarb_if.slave bus
);

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  // A zero timeout would never let BUSY make progress; reject it at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("gfx256_rdarb: TIMEOUT_CYCLES must be at least 1");
  end

  // Requester lanes gathered into packed vectors so selection can be indexed.
  logic [NUM_REQ-1:0]       req_v;
  logic [NUM_REQ-1:0][31:0] addr_v;
  logic [NUM_REQ-1:0][31:0] sel_v;

  assign req_v  = {bus.req2_i, bus.req1_i, bus.req0_i};
  assign addr_v = {bus.addr2_i, bus.addr1_i, bus.addr0_i};
  assign sel_v  = {bus.sel2_i, bus.sel1_i, bus.sel0_i};

  state_e              state_q;
  logic [1:0]          grant_q;
  logic [1:0]          last_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                wbm_req_q;
  logic [31:0]         wbm_addr_q;
  logic [31:0]         wbm_sel_q;
  logic [31:0]         data_q;

  logic [1:0]          win_d;
  logic                any_req;

  assign any_req = |req_v;

  // Round-robin pick: scan from last+1 around the ring, first active wins.
  // Scanning the distances backwards lets the nearest requester overwrite.
  always_comb begin
    win_d = last_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int c;
      c = (int'(last_q) + i) % NUM_REQ;
      if (req_v[c]) win_d = 2'(c);
    end
  end

`ifdef GFX256_RDARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
`endif

  // Arbiter FSM: grant in IDLE, hold the reader request in BUSY, then a
  // one-cycle RELEASE so a freshly acked requester cannot be re-granted
  // before it has a chance to drop its request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= 2'd0;
      last_q     <= 2'd2;
      ack_q      <= '0;
      wbm_req_q  <= 1'b0;
      wbm_addr_q <= '0;
      wbm_sel_q  <= 32'hFFFF_FFFF;
      data_q     <= '0;
`ifdef GFX256_RDARB_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
`ifdef GFX256_RDARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (any_req && !bus.wbm_busy_i) begin
            grant_q    <= win_d;
            wbm_addr_q <= addr_v[win_d];
            wbm_sel_q  <= sel_v[win_d];
            wbm_req_q  <= 1'b1;
            state_q    <= BUSY;
`ifdef GFX256_RDARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus.wbm_ack_i) begin
            wbm_req_q      <= 1'b0;
            data_q         <= bus.wbm_data_i;
            ack_q[grant_q] <= 1'b1;
            last_q         <= grant_q;
            state_q        <= RELEASE;
          end
`ifdef GFX256_RDARB_TIMEOUT_EN
          // Counter holds the number of BUSY cycles already spent; the
          // completion edge lands at the end of cycle TIMEOUT_CYCLES.
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            wbm_req_q      <= 1'b0;
            data_q         <= 32'hFFFF_FFFF;
            ack_q[grant_q] <= 1'b1;
            last_q         <= grant_q;
            timeout_q      <= 1'b1;
            state_q        <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0_o        = ack_q[0];
  assign bus.ack1_o        = ack_q[1];
  assign bus.ack2_o        = ack_q[2];
  assign bus.data_o        = data_q;
  assign bus.wbm_request_o = wbm_req_q;
  assign bus.wbm_addr_o    = wbm_addr_q;
  assign bus.wbm_sel_o     = wbm_sel_q;
  assign bus.grant_o       = grant_q;
  assign bus.busy_o        = (state_q != IDLE);
`ifdef GFX256_RDARB_TIMEOUT_EN
  assign bus.timeout_o     = timeout_q;
`else
  assign bus.timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_gfx256_rdarb.sv
// Self-checking bench for gfx256_rdarb: directed scenarios plus randomized
// transactions checked against a round-robin reference kept here.
module tb_gfx256_rdarb;
  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  gfx256_rdarb_if bus();

  gfx256_rdarb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int m_last = 2;  // reference model: last requester served

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [2:0] acks;
    return {bus.ack2_o, bus.ack1_o, bus.ack0_o};
  endfunction

  // Reference: first active requester at distance 1,2,3 from the last owner.
  function automatic int exp_winner(input logic [2:0] r);
    for (int i = 1; i <= 3; i++) begin
      int c;
      c = (m_last + i) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input logic [2:0] r);
    bus.req0_i = r[0];
    bus.req1_i = r[1];
    bus.req2_i = r[2];
  endtask

  task automatic do_reset;
    #2 rst_ni = 1'b0;
    tick;
    tick;
    rst_ni = 1'b1;
    m_last = 2;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    tick;
    tick;
    checks++; if (bus.wbm_request_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.wbm_request_o); end
    checks++; if (bus.wbm_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", bus.wbm_addr_o); end
    checks++; if (bus.wbm_sel_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_sel got %h want ffffffff", bus.wbm_sel_o); end
    checks++; if (acks() !== 3'b000) begin errors++; $display("FAIL rst_acks got %b want 000", acks()); end
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", bus.data_o); end
    checks++; if (bus.grant_o !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d want 0", bus.grant_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy_o); end
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", bus.timeout_o); end
    rst_ni = 1'b1;
    m_last = 2;
  endtask

  task automatic test_basic;
    bus.addr1_i = 32'h1000;
    bus.sel1_i  = 32'h0000_000F;
    set_req(3'b010);
    tick;
    checks++; if (bus.wbm_request_o !== 1'b1) begin errors++; $display("FAIL basic_req got %b want 1", bus.wbm_request_o); end
    checks++; if (bus.wbm_addr_o !== 32'h1000) begin errors++; $display("FAIL basic_addr got %h want 00001000", bus.wbm_addr_o); end
    checks++; if (bus.grant_o !== 2'd1) begin errors++; $display("FAIL basic_grant got %0d want 1", bus.grant_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bus.busy_o); end
    tick;
    tick;
    bus.wbm_ack_i  = 1'b1;
    bus.wbm_data_i = 32'hCAFE_BABE;
    tick;
    bus.wbm_ack_i = 1'b0;
    set_req(3'b000);
    checks++; if (acks() !== 3'b010) begin errors++; $display("FAIL basic_ack got %b want 010", acks()); end
    checks++; if (bus.data_o !== 32'hCAFE_BABE) begin errors++; $display("FAIL basic_data got %h want cafebabe", bus.data_o); end
    checks++; if (bus.wbm_request_o !== 1'b0) begin errors++; $display("FAIL basic_reqdrop got %b want 0", bus.wbm_request_o); end
    m_last = 1;
    tick;
    checks++; if (acks() !== 3'b000) begin errors++; $display("FAIL basic_ackpulse got %b want 000", acks()); end
  endtask

  task automatic test_round_robin;
    int order [4] = '{0, 1, 2, 0};
    do_reset();
    bus.addr0_i = 32'hA0; bus.addr1_i = 32'hA1; bus.addr2_i = 32'hA2;
    set_req(3'b111);
    for (int n = 0; n < 4; n++) begin
      tick;
      checks++; if (int'(bus.grant_o) !== order[n]) begin errors++; $display("FAIL rr_grant%0d got %0d want %0d", n, bus.grant_o, order[n]); end
      checks++; if (bus.wbm_addr_o !== 32'hA0 + 32'(order[n])) begin errors++; $display("FAIL rr_addr%0d got %h want %h", n, bus.wbm_addr_o, 32'hA0 + 32'(order[n])); end
      tick;
      bus.wbm_ack_i  = 1'b1;
      bus.wbm_data_i = 32'h5000 + 32'(n);
      tick;
      bus.wbm_ack_i = 1'b0;
      checks++; if (acks() !== 3'(1 << order[n])) begin errors++; $display("FAIL rr_ack%0d got %b want %b", n, acks(), 3'(1 << order[n])); end
      m_last = order[n];
      tick;
      checks++; if (bus.wbm_request_o !== 1'b0 || acks() !== 3'b000) begin errors++; $display("FAIL rr_release%0d got req=%b acks=%b want 0/000", n, bus.wbm_request_o, acks()); end
    end
    set_req(3'b000);
  endtask

  task automatic test_busy_hold;
    bus.addr2_i = 32'h2222;
    set_req(3'b100);
    bus.wbm_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (bus.wbm_request_o !== 1'b0) begin errors++; $display("FAIL hold_req%0d got %b want 0", i, bus.wbm_request_o); end
    end
    bus.wbm_busy_i = 1'b0;
    tick;
    checks++; if (bus.wbm_request_o !== 1'b1 || bus.grant_o !== 2'd2) begin errors++; $display("FAIL hold_grant got req=%b grant=%0d want 1/2", bus.wbm_request_o, bus.grant_o); end
    bus.wbm_ack_i  = 1'b1;
    bus.wbm_data_i = 32'h1234_5678;
    tick;
    bus.wbm_ack_i = 1'b0;
    set_req(3'b000);
    checks++; if (acks() !== 3'b100) begin errors++; $display("FAIL hold_ack got %b want 100", acks()); end
    m_last = 2;
    tick;
  endtask

  task automatic test_reset_mid;
    set_req(3'b001);
    tick;
    checks++; if (bus.wbm_request_o !== 1'b1) begin errors++; $display("FAIL rmid_grant got %b want 1", bus.wbm_request_o); end
    set_req(3'b000);
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (bus.wbm_request_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_async got req=%b busy=%b want 0/0", bus.wbm_request_o, bus.busy_o); end
    #1 rst_ni = 1'b1;
    m_last = 2;
    bus.wbm_ack_i  = 1'b1;
    bus.wbm_data_i = 32'hDEAD_BEEF;
    tick;
    bus.wbm_ack_i = 1'b0;
    tick;
    checks++; if (acks() !== 3'b000 || bus.wbm_request_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_stray got acks=%b req=%b busy=%b want 000/0/0", acks(), bus.wbm_request_o, bus.busy_o); end
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL rmid_data got %h want 0", bus.data_o); end
  endtask

`ifdef GFX256_RDARB_TIMEOUT_EN
  task automatic test_timeout;
    set_req(3'b001);
    tick;
    checks++; if (bus.grant_o !== 2'd0 || bus.wbm_request_o !== 1'b1) begin errors++; $display("FAIL to_grant got grant=%0d req=%b want 0/1", bus.grant_o, bus.wbm_request_o); end
    set_req(3'b000);
    for (int i = 1; i < TO; i++) begin
      tick;
      checks++; if (acks() !== 3'b000 || bus.timeout_o !== 1'b0) begin errors++; $display("FAIL to_early%0d got acks=%b to=%b want 000/0", i, acks(), bus.timeout_o); end
    end
    tick;
    checks++; if (acks() !== 3'b001 || bus.timeout_o !== 1'b1) begin errors++; $display("FAIL to_fire got acks=%b to=%b want 001/1", acks(), bus.timeout_o); end
    checks++; if (bus.data_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_data got %h want ffffffff", bus.data_o); end
    m_last = 0;
    tick;
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL to_pulse got %b want 0", bus.timeout_o); end
  endtask
`endif

  task automatic test_random;
    for (int t = 0; t < 40; t++) begin
      logic [2:0]  r;
      logic [31:0] a [3];
      logic [31:0] s [3];
      logic [31:0] d;
      int w, hold, waitc;
      r = 3'($urandom_range(1, 7));
      for (int k = 0; k < 3; k++) begin a[k] = $urandom; s[k] = $urandom; end
      bus.addr0_i = a[0]; bus.addr1_i = a[1]; bus.addr2_i = a[2];
      bus.sel0_i  = s[0]; bus.sel1_i  = s[1]; bus.sel2_i  = s[2];
      set_req(r);
      hold = $urandom_range(0, 2);
      bus.wbm_busy_i = (hold != 0);
      for (int i = 0; i < hold; i++) begin
        tick;
        checks++; if (bus.wbm_request_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_busyhold got %b want 0", t, bus.wbm_request_o); end
      end
      bus.wbm_busy_i = 1'b0;
      w = exp_winner(r);
      tick;
      checks++; if (bus.wbm_request_o !== 1'b1 || int'(bus.grant_o) !== w) begin errors++; $display("FAIL rnd%0d_grant got req=%b grant=%0d want 1/%0d", t, bus.wbm_request_o, bus.grant_o, w); end
      checks++; if (bus.wbm_addr_o !== a[w] || bus.wbm_sel_o !== s[w]) begin errors++; $display("FAIL rnd%0d_addrsel got %h/%h want %h/%h", t, bus.wbm_addr_o, bus.wbm_sel_o, a[w], s[w]); end
      waitc = $urandom_range(0, 4);
      for (int i = 0; i < waitc; i++) begin
        set_req(3'($urandom_range(0, 7)));
        bus.addr0_i = $urandom; bus.addr1_i = $urandom; bus.addr2_i = $urandom;
        tick;
        checks++; if (bus.wbm_request_o !== 1'b1 || bus.wbm_addr_o !== a[w] || acks() !== 3'b000) begin errors++; $display("FAIL rnd%0d_busy got req=%b addr=%h acks=%b want 1/%h/000", t, bus.wbm_request_o, bus.wbm_addr_o, acks(), a[w]); end
      end
      d = $urandom;
      bus.wbm_ack_i  = 1'b1;
      bus.wbm_data_i = d;
      tick;
      bus.wbm_ack_i = 1'b0;
      checks++; if (acks() !== 3'(1 << w) || bus.data_o !== d) begin errors++; $display("FAIL rnd%0d_done got acks=%b data=%h want %b/%h", t, acks(), bus.data_o, 3'(1 << w), d); end
      m_last = w;
      set_req(3'($urandom_range(0, 7)));
      tick;
      checks++; if (acks() !== 3'b000 || bus.wbm_request_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_release got acks=%b req=%b want 000/0", t, acks(), bus.wbm_request_o); end
      set_req(3'b000);
    end
  endtask

  initial begin
    set_req(3'b000);
    bus.addr0_i = '0; bus.addr1_i = '0; bus.addr2_i = '0;
    bus.sel0_i = '0; bus.sel1_i = '0; bus.sel2_i = '0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_data_i = '0;
    bus.wbm_busy_i = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_busy_hold();
    test_reset_mid();
`ifdef GFX256_RDARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

endmodule
